// File: rtl/reorder_buffer_if.sv
// Interface bundling the dispatch, completion-broadcast, squash and retire
// signals of the reorder buffer. The ROB itself uses the slave modport; the
// front end / execution side uses the master modport.
interface reorder_buffer_if #(
    parameter int ROB_LEN = 8,
    parameter int REG_LEN = 5
);
    localparam int TAG_W = $clog2(ROB_LEN);

    logic               dispatch_valid;
    logic [REG_LEN-1:0] dispatch_dest_idx;
    logic [TAG_W-1:0]   alloc_tag;
    logic               alloc_valid;
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic               squash;
    logic               retire;
    logic [TAG_W-1:0]   head_idx;
    logic [REG_LEN-1:0] retire_dest_idx;
    logic               full;
    logic               empty;
    logic [TAG_W:0]     count;

    modport master (
        output dispatch_valid, dispatch_dest_idx, cdb_valid, cdb_tag, squash,
        input  alloc_tag, alloc_valid, retire, head_idx, retire_dest_idx,
               full, empty, count
    );

    modport slave (
        input  dispatch_valid, dispatch_dest_idx, cdb_valid, cdb_tag, squash,
        output alloc_tag, alloc_valid, retire, head_idx, retire_dest_idx,
               full, empty, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular array of ROB_LEN entries (valid, complete, dest_idx)
// allocated in order at the tail, completed out of order by the CDB and retired
// in order from the head. Squash flushes every entry and rewinds the pointers.
// Optional macro ROB_CDB_BYPASS_EN lets a CDB broadcast for the head entry
// retire it in the same cycle instead of waiting for the registered complete bit.
module reorder_buffer #(
    parameter int ROB_LEN = 8,
    parameter int REG_LEN = 5
) (
    input  logic            clock,
    input  logic            reset,
    reorder_buffer_if.slave bus
);
    localparam int             TAG_W      = $clog2(ROB_LEN);
    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_LEN);

    logic [ROB_LEN-1:0] r_valid;
    logic [ROB_LEN-1:0] r_complete;
    logic [REG_LEN-1:0] r_dest [ROB_LEN];
    logic [TAG_W-1:0]   r_head;
    logic [TAG_W-1:0]   r_tail;
    logic [TAG_W:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_alloc;
    logic w_head_done;
    logic w_retire;

`ifdef ROB_CDB_BYPASS_EN
    assign w_head_done = r_complete[r_head] | (bus.cdb_valid & (bus.cdb_tag == r_head));
`else
    assign w_head_done = r_complete[r_head];
`endif

    // Handshake decisions; full comes from the registered count only, and
    // both grants are forced low while reset is held.
    always_comb begin
        w_full   = (r_count == FULL_COUNT);
        w_empty  = (r_count == '0);
        w_alloc  = reset & bus.dispatch_valid & ~w_full & ~bus.squash;
        w_retire = reset & r_valid[r_head] & w_head_done & ~bus.squash;
    end

    // Per-entry state: allocate at tail, mark complete from CDB, clear at head on retire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid    <= '0;
            r_complete <= '0;
            for (int unsigned i = 0; i < unsigned'(ROB_LEN); i++) begin
                r_dest[i] <= '0;
            end
        end else if (bus.squash) begin
            r_valid    <= '0;
            r_complete <= '0;
        end else begin
            if (bus.cdb_valid && r_valid[bus.cdb_tag]) begin
                r_complete[bus.cdb_tag] <= 1'b1;
            end
            if (w_retire) begin
                r_valid[r_head]    <= 1'b0;
                r_complete[r_head] <= 1'b0;
            end
            if (w_alloc) begin
                r_valid[r_tail]    <= 1'b1;
                r_complete[r_tail] <= 1'b0;
                r_dest[r_tail]     <= bus.dispatch_dest_idx;
            end
        end
    end

    // Head/tail pointers wrap naturally (power-of-two length); count tracks occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + TAG_W'(w_retire);
            r_tail  <= r_tail + TAG_W'(w_alloc);
            r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_retire);
        end
    end

    assign bus.alloc_valid     = w_alloc;
    assign bus.alloc_tag       = r_tail;
    assign bus.retire          = w_retire;
    assign bus.head_idx        = r_head;
    assign bus.retire_dest_idx = r_dest[r_head];
    assign bus.full            = w_full;
    assign bus.empty           = w_empty;
    assign bus.count           = r_count;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a queue-based model of in-order
// allocation / out-of-order completion / in-order retirement is compared
// against every DUT output on each falling edge, and directed sequences carry
// hand-computed literal expectations.
module tb_reorder_buffer;
    localparam int ROB_LEN = 8;
    localparam int REG_LEN = 5;
`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    reorder_buffer_if #(.ROB_LEN(ROB_LEN), .REG_LEN(REG_LEN)) rob_bus ();

    reorder_buffer #(.ROB_LEN(ROB_LEN), .REG_LEN(REG_LEN)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (rob_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int tag;
        int dest;
        bit comp;
    } ent_t;

    ent_t q[$];
    int   m_head = 0;
    int   m_tail = 0;
    int   m_mem [ROB_LEN];

    always @(negedge clk) begin
        int   sz;
        bit   e_alc;
        bit   e_ret;
        int   ct;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_head = 0;
            m_tail = 0;
            for (int k = 0; k < ROB_LEN; k++) m_mem[k] = 0;
        end
        sz = q.size();
        ct = int'(rob_bus.cdb_tag);
        e_alc = rst_n && rob_bus.dispatch_valid && (sz < ROB_LEN) && !rob_bus.squash;
        e_ret = rst_n && (sz > 0) && !rob_bus.squash &&
                (q[0].comp || (BYP && rob_bus.cdb_valid && ct == q[0].tag));
        chk("m_alloc_valid", 32'(rob_bus.alloc_valid), 32'(e_alc));
        chk("m_alloc_tag",   32'(rob_bus.alloc_tag),   m_tail);
        chk("m_retire",      32'(rob_bus.retire),      32'(e_ret));
        chk("m_head_idx",    32'(rob_bus.head_idx),    m_head);
        chk("m_retire_dest", 32'(rob_bus.retire_dest_idx), m_mem[m_head]);
        chk("m_full",        32'(rob_bus.full),        32'(sz == ROB_LEN));
        chk("m_empty",       32'(rob_bus.empty),       32'(sz == 0));
        chk("m_count",       32'(rob_bus.count),       sz);
        if (rst_n) begin
            if (rob_bus.squash) begin
                q.delete();
                m_head = 0;
                m_tail = 0;
            end else begin
                if (rob_bus.cdb_valid)
                    foreach (q[k]) if (q[k].tag == ct) q[k].comp = 1'b1;
                if (e_ret) begin
                    void'(q.pop_front());
                    m_head = (m_head + 1) % ROB_LEN;
                end
                if (e_alc) begin
                    e.tag  = m_tail;
                    e.dest = int'(rob_bus.dispatch_dest_idx);
                    e.comp = 1'b0;
                    q.push_back(e);
                    m_mem[m_tail] = e.dest;
                    m_tail = (m_tail + 1) % ROB_LEN;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit dv, input int dest, input bit cv, input int ct, input bit sq);
        rob_bus.dispatch_valid    = dv;
        rob_bus.dispatch_dest_idx = REG_LEN'(dest);
        rob_bus.cdb_valid         = cv;
        rob_bus.cdb_tag           = 3'(ct);
        rob_bus.squash            = sq;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        step();
        #2;
        chk("rst_empty",   32'(rob_bus.empty), 1);
        chk("rst_full",    32'(rob_bus.full), 0);
        chk("rst_head",    32'(rob_bus.head_idx), 0);
        chk("rst_tag",     32'(rob_bus.alloc_tag), 0);
        step();
        rst_n = 1'b1;

        // three dispatches after reset
        for (int i = 0; i < 3; i++) begin
            drive(1, 3 + i, 0, 0, 0);
            #2;
            chk("d3_alloc_tag",   32'(rob_bus.alloc_tag), i);
            chk("d3_alloc_valid", 32'(rob_bus.alloc_valid), 1);
            step();
        end
        drive(0, 0, 0, 0, 0);
        #2;
        chk("d3_count", 32'(rob_bus.count), 3);
        chk("d3_empty", 32'(rob_bus.empty), 0);

        // out-of-order completion 2,1,0 -> in-order retirement 0,1,2
        step();
        drive(0, 0, 1, 2, 0);
        #2;
        chk("ooo_ret_t2", 32'(rob_bus.retire), 0);
        step();
        drive(0, 0, 1, 1, 0);
        #2;
        chk("ooo_ret_t1", 32'(rob_bus.retire), 0);
        step();
        drive(0, 0, 1, 0, 0);
        #2;
`ifdef ROB_CDB_BYPASS_EN
        chk("byp_same_cycle_ret", 32'(rob_bus.retire), 1);
        chk("byp_head0", 32'(rob_bus.head_idx), 0);
        chk("byp_dest0", 32'(rob_bus.retire_dest_idx), 3);
        for (int i = 1; i < 3; i++) begin
            step();
            drive(0, 0, 0, 0, 0);
            #2;
            chk("ooo_retire", 32'(rob_bus.retire), 1);
            chk("ooo_head",   32'(rob_bus.head_idx), i);
            chk("ooo_dest",   32'(rob_bus.retire_dest_idx), 3 + i);
        end
`else
        chk("nobyp_no_same_cycle_ret", 32'(rob_bus.retire), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            drive(0, 0, 0, 0, 0);
            #2;
            chk("ooo_retire", 32'(rob_bus.retire), 1);
            chk("ooo_head",   32'(rob_bus.head_idx), i);
            chk("ooo_dest",   32'(rob_bus.retire_dest_idx), 3 + i);
        end
`endif
        step();
        #2;
        chk("ooo_drained", 32'(rob_bus.empty), 1);
        step();

        // squash with four valid entries, dispatch and CDB active
        for (int i = 0; i < 4; i++) begin
            drive(1, 20 + i, 0, 0, 0);
            step();
        end
        drive(1, 24, 1, 3, 1);
        #2;
        chk("sq_count_before", 32'(rob_bus.count), 4);
        chk("sq_alloc_valid",  32'(rob_bus.alloc_valid), 0);
        chk("sq_retire",       32'(rob_bus.retire), 0);
        step();
        drive(0, 0, 0, 0, 0);
        #2;
        chk("sq_count", 32'(rob_bus.count), 0);
        chk("sq_empty", 32'(rob_bus.empty), 1);
        chk("sq_tag",   32'(rob_bus.alloc_tag), 0);
        chk("sq_head",  32'(rob_bus.head_idx), 0);
        step();

        // fill to full, hold dispatch, free one slot, wrap tag to 0
        for (int i = 0; i < 8; i++) begin
            drive(1, 10 + i, 0, 0, 0);
            #2;
            chk("fill_tag", 32'(rob_bus.alloc_tag), i);
            step();
        end
        #2;
        chk("full_flag",        32'(rob_bus.full), 1);
        chk("full_alloc_valid", 32'(rob_bus.alloc_valid), 0);
        step();
        drive(1, 30, 1, 0, 0);
        #2;
`ifdef ROB_CDB_BYPASS_EN
        chk("full_cdb_retire", 32'(rob_bus.retire), 1);
        chk("full_cdb_alloc",  32'(rob_bus.alloc_valid), 0);
        step();
        drive(1, 30, 0, 0, 0);
`else
        chk("full_cdb_retire", 32'(rob_bus.retire), 0);
        step();
        drive(1, 30, 0, 0, 0);
        #2;
        chk("full_ret_cycle_retire", 32'(rob_bus.retire), 1);
        chk("full_ret_cycle_full",   32'(rob_bus.full), 1);
        chk("full_ret_cycle_alloc",  32'(rob_bus.alloc_valid), 0);
        step();
`endif
        #2;
        chk("wrap_full",  32'(rob_bus.full), 0);
        chk("wrap_alloc", 32'(rob_bus.alloc_valid), 1);
        chk("wrap_tag",   32'(rob_bus.alloc_tag), 0);
        step();
        drive(0, 0, 0, 0, 1);
        step();

        // asynchronous reset mid-stream at count 5
        for (int i = 0; i < 5; i++) begin
            drive(1, 1 + i, 0, 0, 0);
            step();
        end
        drive(0, 0, 1, 0, 0);
        #2;
        chk("ar_count5", 32'(rob_bus.count), 5);
        step();
        drive(1, 9, 1, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("ar_count",  32'(rob_bus.count), 0);
        chk("ar_retire", 32'(rob_bus.retire), 0);
        chk("ar_alloc",  32'(rob_bus.alloc_valid), 0);
        chk("ar_empty",  32'(rob_bus.empty), 1);
        step();
        step();
        rst_n = 1'b1;
        drive(1, 9, 0, 0, 0);
        #2;
        chk("ar_resume_valid", 32'(rob_bus.alloc_valid), 1);
        chk("ar_resume_tag",   32'(rob_bus.alloc_tag), 0);
        step();

        // mixed traffic checked by the model
        for (int i = 0; i < 48; i++) begin
            drive((i % 3) != 2, i % 32, (i % 2) == 1, (i * 5) % 8, i == 30);
            step();
        end
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1, i % 8, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
